// File: rtl/rf_iw_fill_ctrl.sv
// -----------------------------------------------------------------------------
// rf_iw_fill_ctrl
//
// Fill controller for a double-buffered activation/weight register file.
// On start it streams DEPTH words out of the global buffer (GB) into the RF
// bank currently selected for writing, then holds that bank as "ready" until
// the MAC side signals it has finished with the read bank, at which point the
// banks are swapped by toggling write_sel.
//
// Optional feature macro: RF_FILL_STRIDE_EN
//   defined   : adds input gb_stride; read address = base + k*gb_stride
//   undefined : stride fixed at 1
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   start               request one bank fill (honoured only when idle)
//   gb_base_addr        GB address of word 0, captured with start
//   gb_stride           (RF_FILL_STRIDE_EN only) address step, captured with start
//   compute_done        level from MAC side: read bank no longer needed
//   gb_r_en, gb_r_addr  registered GB read strobe/address
//   gb_r_data           GB read data, valid the cycle after gb_r_en
//   write_sel           RF bank select (1: write mem1, read mem2)
//   write_en            RF write strobe
//   w_addr1, w_addr2    RF write address (same value on both ports)
//   w_data1, w_data2    RF write data (pass-through of gb_r_data)
//   busy                fill in progress
//   fill_done           one-cycle pulse after the last word is written
//   bank_ready          write bank holds a complete, not yet swapped fill
//   swap                one-cycle pulse in the cycle write_sel changes
// -----------------------------------------------------------------------------
module rf_iw_fill_ctrl #(
    parameter int DATA_BITWIDTH    = 8,
    parameter int ADDR_BITWIDTH    = 2,
    parameter int DEPTH            = 4,
    parameter int GB_ADDR_BITWIDTH = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [GB_ADDR_BITWIDTH-1:0] gb_base_addr,
`ifdef RF_FILL_STRIDE_EN
    input  logic [GB_ADDR_BITWIDTH-1:0] gb_stride,
`endif
    input  logic                        compute_done,
    output logic                        gb_r_en,
    output logic [GB_ADDR_BITWIDTH-1:0] gb_r_addr,
    input  logic [DATA_BITWIDTH-1:0]    gb_r_data,
    output logic                        write_sel,
    output logic                        write_en,
    output logic [ADDR_BITWIDTH-1:0]    w_addr1,
    output logic [ADDR_BITWIDTH-1:0]    w_addr2,
    output logic [DATA_BITWIDTH-1:0]    w_data1,
    output logic [DATA_BITWIDTH-1:0]    w_data2,
    output logic                        busy,
    output logic                        fill_done,
    output logic                        bank_ready,
    output logic                        swap
);

    localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [KW-1:0]               k;
    logic [ADDR_BITWIDTH-1:0]    w_addr;
    logic [GB_ADDR_BITWIDTH-1:0] stride;
    logic                        accept;
    logic                        last_read;
    logic                        do_swap;

    assign accept    = (state == IDLE) && start;
    assign last_read = (state == ISSUE) && (k == K_LAST);
    assign do_swap   = (state == FULL) && compute_done;

`ifdef RF_FILL_STRIDE_EN
    logic [GB_ADDR_BITWIDTH-1:0] stride_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stride_q <= '0;
        else if (accept)
            stride_q <= gb_stride;
    end

    assign stride = stride_q;
`else
    assign stride = GB_ADDR_BITWIDTH'(1);
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)        state_nxt = ISSUE;
            ISSUE:   if (k == K_LAST)  state_nxt = DRAIN;
            DRAIN:                     state_nxt = FULL;
            FULL:    if (compute_done) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    // k indexes the read currently on gb_r_addr; the RF write for that word
    // happens one cycle later, so write_en/w_addr are simply delayed copies.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k          <= '0;
            gb_r_en    <= 1'b0;
            gb_r_addr  <= '0;
            write_en   <= 1'b0;
            w_addr     <= '0;
            write_sel  <= 1'b1;
            fill_done  <= 1'b0;
            bank_ready <= 1'b0;
            swap       <= 1'b0;
        end else begin
            write_en  <= gb_r_en;
            w_addr    <= ADDR_BITWIDTH'(k);
            fill_done <= (state == DRAIN);
            swap      <= do_swap;

            if (accept) begin
                gb_r_en   <= 1'b1;
                gb_r_addr <= gb_base_addr;
                k         <= '0;
            end else if (last_read) begin
                gb_r_en <= 1'b0;
                k       <= '0;
            end else if (state == ISSUE) begin
                k         <= k + KW'(1);
                gb_r_addr <= gb_r_addr + stride;  // wraps modulo GB size
            end

            if (state == DRAIN)
                bank_ready <= 1'b1;
            else if (do_swap)
                bank_ready <= 1'b0;

            if (do_swap)
                write_sel <= ~write_sel;
        end
    end

    assign busy    = (state == ISSUE) || (state == DRAIN);
    assign w_addr1 = w_addr;
    assign w_addr2 = w_addr;
    assign w_data1 = gb_r_data;
    assign w_data2 = gb_r_data;

endmodule

// File: tb/tb_rf_iw_fill_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for rf_iw_fill_ctrl (DEPTH=4, 2-bit RF address, 8-bit data,
// 10-bit GB address). A behavioural model tracks the controller as
// "idle / filling for t cycles / full" and derives every expected output from
// the time since start; a negedge process compares all outputs each cycle.
// Directed sequences pin literal values; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_rf_iw_fill_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int GW    = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [GW-1:0] gb_base_addr = '0;
    logic          compute_done = 1'b0;
    logic          gb_r_en;
    logic [GW-1:0] gb_r_addr;
    logic [DW-1:0] gb_r_data = '0;
    logic          write_sel, write_en, busy, fill_done, bank_ready, swap;
    logic [AW-1:0] w_addr1, w_addr2;
    logic [DW-1:0] w_data1, w_data2;

`ifdef RF_FILL_STRIDE_EN
    logic [GW-1:0] gb_stride = 10'd1;
    wire  [GW-1:0] stride_in = gb_stride;
`else
    wire  [GW-1:0] stride_in = 10'd1;
`endif

    rf_iw_fill_ctrl #(
        .DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW),
        .DEPTH(DEPTH), .GB_ADDR_BITWIDTH(GW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .gb_base_addr(gb_base_addr),
`ifdef RF_FILL_STRIDE_EN
        .gb_stride(gb_stride),
`endif
        .compute_done(compute_done),
        .gb_r_en(gb_r_en), .gb_r_addr(gb_r_addr), .gb_r_data(gb_r_data),
        .write_sel(write_sel), .write_en(write_en),
        .w_addr1(w_addr1), .w_addr2(w_addr2),
        .w_data1(w_data1), .w_data2(w_data2),
        .busy(busy), .fill_done(fill_done),
        .bank_ready(bank_ready), .swap(swap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- GB memory
    logic [DW-1:0] gbmem [1 << GW];

    always @(posedge clk)
        gb_r_data <= gb_r_en ? gbmem[gb_r_addr] : DW'($urandom);

    // ---------------------------------------------------------- model
    // phase 0 idle, 1 filling (t = cycles since start), 2 full.
    int            m_phase = 0;
    int            m_t = 0;
    logic [GW-1:0] m_base = '0;
    logic [GW-1:0] m_stride = '0;
    logic          m_sel = 1'b1;
    logic          m_swap = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_t = 0; m_sel = 1'b1; m_swap = 1'b0;
        end else begin
            m_swap = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_phase = 1; m_t = 1; m_base = gb_base_addr; m_stride = stride_in;
                end
                1: begin
                    m_t++;
                    if (m_t == DEPTH + 2) m_phase = 2;
                end
                default: begin
                    if (m_t < DEPTH + 3) m_t++;
                    if (compute_done) begin
                        m_phase = 0; m_sel = ~m_sel; m_swap = 1'b1;
                    end
                end
            endcase
        end
    end

    function automatic logic [GW-1:0] m_addr(input int idx);
        return m_base + GW'(idx * int'(m_stride));
    endfunction

    // ---------------------------------------------------------- compare
    always @(negedge clk) begin
        bit e_ren, e_wen;
        e_ren = (m_phase == 1) && (m_t <= DEPTH);
        e_wen = (m_phase == 1) && (m_t >= 2) && (m_t <= DEPTH + 1);
        chk("gb_r_en",    int'(gb_r_en),    int'(e_ren));
        chk("write_en",   int'(write_en),   int'(e_wen));
        chk("busy",       int'(busy),       int'(m_phase == 1));
        chk("fill_done",  int'(fill_done),  int'(m_phase == 2 && m_t == DEPTH + 2));
        chk("bank_ready", int'(bank_ready), int'(m_phase == 2));
        chk("swap",       int'(swap),       int'(m_swap));
        chk("write_sel",  int'(write_sel),  int'(m_sel));
        chk("w_data1_pt", int'(w_data1),    int'(gb_r_data));
        chk("w_data2_pt", int'(w_data2),    int'(gb_r_data));
        if (e_ren)
            chk("gb_r_addr", int'(gb_r_addr), int'(m_addr(m_t - 1)));
        if (e_wen) begin
            chk("w_addr1", int'(w_addr1), (m_t - 2) % (1 << AW));
            chk("w_addr2", int'(w_addr2), (m_t - 2) % (1 << AW));
            chk("w_data",  int'(w_data1), int'(gbmem[m_addr(m_t - 2)]));
        end
    end

    // ---------------------------------------------------------- helpers
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_stride(input logic [GW-1:0] s);
`ifdef RF_FILL_STRIDE_EN
        gb_stride = s;
`else
        if (s != 10'd1) $display("note: stride %0d ignored in fixed-stride build", s);
`endif
    endtask

    // Runs one fill from cycle 0 (now) to cycle DEPTH+2 with literal checks.
    task automatic run_fill(input logic [GW-1:0] base, input logic [GW-1:0] s,
                            input logic [3:0][GW-1:0] ea, input logic [3:0][DW-1:0] ed,
                            input bit poke, input bit sel_exp);
        start = 1'b1; gb_base_addr = base; set_stride(s);
        for (int c = 1; c <= DEPTH + 2; c++) begin
            step;
            start = poke && (c == 2);
            if (c <= DEPTH) begin
                chk("lit_ren", int'(gb_r_en), 1);
                chk("lit_addr", int'(gb_r_addr), int'(ea[c-1]));
            end
            if (c >= 2 && c <= DEPTH + 1) begin
                chk("lit_wen", int'(write_en), 1);
                chk(sel_exp ? "lit_waddr1" : "lit_waddr2",
                    sel_exp ? int'(w_addr1) : int'(w_addr2), c - 2);
                chk("lit_wdata", sel_exp ? int'(w_data1) : int'(w_data2), int'(ed[c-2]));
            end
            chk("lit_sel", int'(write_sel), int'(sel_exp));
        end
        chk("lit_fill_done", int'(fill_done), 1);
        chk("lit_bank_ready", int'(bank_ready), 1);
    endtask

    task automatic do_swap(input bit sel_after);
        compute_done = 1'b1;
        step;
        compute_done = 1'b0;
        chk("lit_swap", int'(swap), 1);
        chk("lit_swap_ready", int'(bank_ready), 0);
        chk("lit_swap_sel", int'(write_sel), int'(sel_after));
    endtask

    // ---------------------------------------------------------- stimulus
    initial begin
        logic [3:0][GW-1:0] ea;
        logic [3:0][DW-1:0] ed;

        for (int i = 0; i < (1 << GW); i++) gbmem[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) begin
            gbmem[10'h010 + i] = 8'hA0 + 8'(i);
            gbmem[10'h020 + i] = 8'h50 + 8'(i);
        end

        // reset values
        repeat (3) step;
        chk("rst_sel", int'(write_sel), 1);
        chk("rst_ren", int'(gb_r_en), 0);
        chk("rst_wen", int'(write_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(fill_done), 0);
        chk("rst_ready", int'(bank_ready), 0);
        chk("rst_swap", int'(swap), 0);
        chk("rst_waddr", int'(w_addr1), 0);
        reset_n = 1'b1;
        step;

        // basic fill with ignored start in cycles 2 and 7
        ea = {10'h013, 10'h012, 10'h011, 10'h010};
        ed = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        run_fill(10'h010, 10'd1, ea, ed, 1'b1, 1'b1);
        step;                      // cycle 7 (FULL)
        start = 1'b1;
        chk("ign_ren7", int'(gb_r_en), 0);
        step;                      // cycle 8
        start = 1'b0;
        chk("ign_ren8", int'(gb_r_en), 0);
        chk("ign_ready8", int'(bank_ready), 1);
        step;                      // cycle 9
        chk("ign_ren9", int'(gb_r_en), 0);
        do_swap(1'b0);

        // compute_done while nothing is ready: no toggle
        compute_done = 1'b1;
        step;
        compute_done = 1'b0;
        chk("ign_cd_sel", int'(write_sel), 0);
        chk("ign_cd_swap", int'(swap), 0);

        // second fill lands via port 2 (write_sel=0)
        ea = {10'h023, 10'h022, 10'h021, 10'h020};
        ed = {8'h53, 8'h52, 8'h51, 8'h50};
        run_fill(10'h020, 10'd1, ea, ed, 1'b0, 1'b0);
        do_swap(1'b1);

        // address wrap
        ea = {10'h001, 10'h000, 10'h3FF, 10'h3FE};
        ed = {gbmem[1], gbmem[0], gbmem[10'h3FF], gbmem[10'h3FE]};
        run_fill(10'h3FE, 10'd1, ea, ed, 1'b0, 1'b1);
        do_swap(1'b0);

        // mid-fill reset
        start = 1'b1; gb_base_addr = 10'h100;
        step; start = 1'b0;
        step;                      // cycle 2
        reset_n = 1'b0;
        #1;
        chk("mrst_ren", int'(gb_r_en), 0);
        chk("mrst_addr", int'(gb_r_addr), 0);
        chk("mrst_wen", int'(write_en), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_sel", int'(write_sel), 1);
        chk("mrst_waddr", int'(w_addr2), 0);
        step; step;
        reset_n = 1'b1;
        step;
`ifdef RF_FILL_STRIDE_EN
        ea = {10'd9, 10'd6, 10'd3, 10'd0};
        ed = {gbmem[9], gbmem[6], gbmem[3], gbmem[0]};
        run_fill(10'h000, 10'd3, ea, ed, 1'b0, 1'b1);
`else
        ea = {10'd3, 10'd2, 10'd1, 10'd0};
        ed = {gbmem[3], gbmem[2], gbmem[1], gbmem[0]};
        run_fill(10'h000, 10'd1, ea, ed, 1'b0, 1'b1);
`endif
        do_swap(1'b0);

        // randomized phase, checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            start = ($urandom_range(3) == 0);
            gb_base_addr = GW'($urandom);
`ifdef RF_FILL_STRIDE_EN
            gb_stride = ($urandom_range(4) == 0) ? 10'd0 : GW'($urandom);
`endif
            if (!compute_done) compute_done = ($urandom_range(5) == 0);
            if ($urandom_range(599) == 0) begin
                reset_n = 1'b0;
                #2;
                reset_n = 1'b1;
            end
            step;
            if (swap) compute_done = 1'b0;
        end

        start = 1'b0;
        compute_done = 1'b0;
        step;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
